access_profile_encoder: RTL and testbench

- Transmit side of the access-profile switch interface. Takes a requested (institution, profile, access-bit) tuple over a valid/ready handshake.
- Encodes the tuple into the 8-bit CH word and 4-bit B function-select word that the profile decoder consumes.
- Holds that word stable for a settle window, then waits a bounded time for the decoder's grant/deny result.
- Sits between the request source (FSM or test sequencer) and the permission decoder, replacing hand-set switches.

---
 rtl/access_profile_encoder.sv | 144 ++++++++++++++
 tb/tb_access_profile_encoder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/access_profile_encoder.sv
// Transmit side of the access-profile switch interface: encodes a requested
// (institution, profile, access) tuple into CH/B words and collects the grant.
module access_profile_encoder #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_ie,
  input  logic [1:0] req_profile,
  input  logic       req_access,
  output logic [7:0] ch_out,
  output logic [3:0] b_out,
  input  logic       resp_valid,
  input  logic       resp_grant,
  output logic       done,
  output logic       granted,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       ch_q, ch_d;
  logic [3:0]       b_q, b_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             granted_q, granted_d;
  logic             timeout_q, timeout_d;
  logic [2:0]       code;

  always_comb begin
    case (req_profile)
      2'd0:    code = 3'b101;
      2'd1:    code = 3'b011;
      2'd2:    code = 3'b001;
      default: code = 3'b110;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ch_d      = ch_q;
    b_d       = b_q;
    granted_d = granted_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        ch_d  = '0;
        b_d   = '0;
        cnt_d = '0;
        // ready_q gates acceptance so the first cycle after reset is never ready
        if (req_valid && ready_q) begin
          state_d = SETTLE;
          ch_d    = req_ie ? {4'b0000, code, req_access} : {code, req_access, 4'b0000};
          b_d     = req_ie ? 4'b0001 : 4'b0100;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT: begin
        if (resp_valid) begin
          granted_d = resp_grant;
          timeout_d = 1'b0;
          state_d   = DONE;
          cnt_d     = '0;
          ch_d      = '0;
          b_d       = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          granted_d = 1'b0;
          timeout_d = 1'b1;
          state_d   = DONE;
          cnt_d     = '0;
          ch_d      = '0;
          b_d       = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        ch_d    = '0;
        b_d     = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        ch_d    = '0;
        b_d     = '0;
      end
    endcase
    ready_d = (state_d == IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ch_q      <= '0;
      b_q       <= '0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      granted_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ch_q      <= ch_d;
      b_q       <= b_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      granted_q <= granted_d;
      timeout_q <= timeout_d;
    end
  end

  assign req_ready = ready_q;
  assign ch_out    = ch_q;
  assign b_out     = b_q;
  assign done      = done_q;
  assign granted   = granted_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_access_profile_encoder.sv
// Self-checking bench for access_profile_encoder: directed scenarios plus
// randomized transactions checked against a cycle-timeline reference model.
module tb_access_profile_encoder;

  localparam int S = 4;
  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_ie = 1'b0;
  logic [1:0] req_profile = 2'd0;
  logic       req_access = 1'b0;
  logic [7:0] ch_out;
  logic [3:0] b_out;
  logic       resp_valid = 1'b0;
  logic       resp_grant = 1'b0;
  logic       done;
  logic       granted;
  logic       timeout;

  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;
  logic exp_granted = 1'b0;
  logic exp_timeout = 1'b0;
  logic [2:0] code_tbl [4] = '{3'b101, 3'b011, 3'b001, 3'b110};

  access_profile_encoder #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T), .CNT_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_ie     (req_ie),
    .req_profile(req_profile),
    .req_access (req_access),
    .ch_out     (ch_out),
    .b_out      (b_out),
    .resp_valid (resp_valid),
    .resp_grant (resp_grant),
    .done       (done),
    .granted    (granted),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && done === 1'b1) done_seen++;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction; resp_cycle counts cycles after the accept edge (-1 = never).
  task automatic apply_stimulus(input logic ie, input logic [1:0] prof, input logic acc,
                                input int resp_cycle, input logic grant, input bit hold);
    int guard;
    int d;
    logic [7:0] exp_ch;
    logic [3:0] exp_b;
    logic res_g;
    logic res_t;
    exp_ch = 8'({code_tbl[prof], acc}) << (ie ? 0 : 4);
    exp_b  = ie ? 4'd1 : 4'd4;
    if (resp_cycle >= S + 1 && resp_cycle <= S + T) begin
      d = resp_cycle + 1;
      res_g = grant;
      res_t = 1'b0;
    end else begin
      d = S + T + 1;
      res_g = 1'b0;
      res_t = 1'b1;
    end
    req_ie = ie;
    req_profile = prof;
    req_access = acc;
    req_valid = 1'b1;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check_output("accept_ready", 8'(req_ready), 8'd1);
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
    for (int k = 1; k <= d + 1; k++) begin
      @(negedge clk);
      if (k == d) begin
        exp_granted = res_g;
        exp_timeout = res_t;
      end
      check_output($sformatf("ready@%0d", k), 8'(req_ready), 8'(k == d + 1));
      check_output($sformatf("done@%0d", k), 8'(done), 8'(k == d));
      check_output($sformatf("granted@%0d", k), 8'(granted), 8'(exp_granted));
      check_output($sformatf("timeout@%0d", k), 8'(timeout), 8'(exp_timeout));
      if (k < d) begin
        check_output($sformatf("ch@%0d", k), ch_out, exp_ch);
        check_output($sformatf("b@%0d", k), 8'(b_out), 8'(exp_b));
      end else if (k == d + 1) begin
        check_output("ch_idle", ch_out, 8'd0);
        check_output("b_idle", 8'(b_out), 8'd0);
      end
      resp_valid = (k == resp_cycle);
      resp_grant = (k == resp_cycle) ? grant : 1'($urandom);
      if (!hold && k < d) begin
        req_ie = 1'($urandom);
        req_profile = 2'($urandom);
        req_access = 1'($urandom);
      end
    end
    resp_valid = 1'b0;
  endtask

  initial begin
    int base;
    int sel;
    int rc;
    // reset state
    #12;
    check_output("rst_ready", 8'(req_ready), 8'd0);
    check_output("rst_ch", ch_out, 8'd0);
    check_output("rst_b", 8'(b_out), 8'd0);
    check_output("rst_done", 8'(done), 8'd0);
    check_output("rst_granted", 8'(granted), 8'd0);
    check_output("rst_timeout", 8'(timeout), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_output("rel_ready_early", 8'(req_ready), 8'd0);
    @(negedge clk);
    check_output("rel_ready", 8'(req_ready), 8'd1);

    apply_stimulus(1'b0, 2'd0, 1'b1, S + 1, 1'b1, 1'b0);
    apply_stimulus(1'b1, 2'd3, 1'b0, S + 1, 1'b0, 1'b0);
    apply_stimulus(1'b0, 2'd2, 1'b1, -1, 1'b1, 1'b0);
    apply_stimulus(1'b0, 2'd2, 1'b1, S + T, 1'b1, 1'b0);
    apply_stimulus(1'b0, 2'd2, 1'b0, 2, 1'b1, 1'b0);

    // abort mid-WAIT with async reset
    req_ie = 1'b0;
    req_profile = 2'd2;
    req_access = 1'b1;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (S + 3) @(negedge clk);
    req_ie = 1'b1;
    req_profile = 2'd0;
    req_access = 1'b0;
    @(negedge clk);
    check_output("wait_ch_held", ch_out, 8'b0011_0000);
    check_output("wait_b_held", 8'(b_out), 8'b0000_0100);
    #2;
    rst_n = 1'b0;
    #1;
    exp_granted = 1'b0;
    exp_timeout = 1'b0;
    check_output("abort_ch", ch_out, 8'd0);
    check_output("abort_b", 8'(b_out), 8'd0);
    check_output("abort_done", 8'(done), 8'd0);
    check_output("abort_ready", 8'(req_ready), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("abort_rel_ready", 8'(req_ready), 8'd1);
    check_output("abort_rel_done", 8'(done), 8'd0);
    check_output("abort_rel_ch", ch_out, 8'd0);

    // req_valid held high across four back-to-back TESTER requests
    base = done_seen;
    apply_stimulus(1'b0, 2'd1, 1'b1, S + 1, 1'b1, 1'b1);
    apply_stimulus(1'b0, 2'd1, 1'b1, S + 2, 1'b0, 1'b1);
    apply_stimulus(1'b0, 2'd1, 1'b1, S + 1, 1'b1, 1'b1);
    apply_stimulus(1'b0, 2'd1, 1'b1, S + 3, 1'b1, 1'b0);
    check_output("four_dones", 8'(done_seen - base), 8'd4);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 3);
      if (sel == 0) rc = -1;
      else if (sel == 1) rc = $urandom_range(1, S);
      else rc = $urandom_range(S + 1, S + T);
      apply_stimulus(1'($urandom), 2'($urandom), 1'($urandom), rc, 1'($urandom), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
